// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target and its bus conditioning block:
// FSM state encoding, address/data widths and the R/W bit meaning.
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int   I2C_ADDR_W  = 7;
    localparam int   I2C_DATA_W  = 8;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings scl/sda into the clk domain and derives bus events from them.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   scl_i/sda_i  raw bus pins
//   sda_o        synchronised sda
//   scl_rise_o   one-cycle pulse on a synchronised scl rising edge
//   scl_fall_o   one-cycle pulse on a synchronised scl falling edge
//   start_det_o  sda fell while scl high (START / repeated START)
//   stop_det_o   sda rose while scl high (STOP)
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    // Flops reset to the idle-bus level (both lines high) so that leaving
    // reset never produces a phantom edge or bus condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign sda_o       = sda_s;
    assign scl_rise_o  =  scl_s & ~scl_hist_q;
    assign scl_fall_o  = ~scl_s &  scl_hist_q;
    assign start_det_o =  scl_s &  sda_hist_q & ~sda_s;
    assign stop_det_o  =  scl_s & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// 7-bit-address I2C target. ACKs its own address, receives write bytes and
// presents them on a one-cycle strobe, and serves read bytes supplied by the
// local side. Never stretches scl; sda is only ever pulled low or released.
//
// Ports:
//   clk       system clock (>= 8x scl)
//   rst       asynchronous active-high reset
//   scl       bus clock (input only)
//   sda       open-drain bus data
//   tx_data   byte to send on reads, captured when tx_load pulses
//   rx_data   last byte received on a write
//   rx_valid  one-cycle strobe: rx_data updated
//   tx_load   one-cycle strobe: tx_data captured
//   busy      high from an address match until STOP
// ---------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_load,
    output logic                  busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl),
        .sda_i       (sda),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    i2c_state_e            state_q,    state_d;
    logic [2:0]            bit_cnt_q,  bit_cnt_d;
    logic [I2C_DATA_W-1:0] shift_q,    shift_d;
    logic [I2C_DATA_W-1:0] rx_data_q,  rx_data_d;
    logic                  rw_q,       rw_d;
    // done_q: the 8th bit of the current byte (or the ACK bit in READ_ACK)
    // has been sampled; the following scl_fall moves to the next phase.
    logic                  done_q,     done_d;
    logic                  sda_oe_q,   sda_oe_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_load_q,  tx_load_d;
    logic                  busy_q,     busy_d;
    logic [I2C_DATA_W-1:0] byte_in;

    assign byte_in = {shift_q[I2C_DATA_W-2:0], sda_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            done_q     <= done_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        done_d     = done_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        // Bus conditions override whatever the current state wants to do,
        // including an ACK drive scheduled for this same cycle.
        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;

                ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                                busy_d = 1'b1;
                                rw_d   = byte_in[0];
                                done_d = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        sda_oe_d = 1'b1;
                        done_d   = 1'b0;
                        state_d  = ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q == I2C_RW_READ) begin
                            shift_d   = tx_data;
                            tx_load_d = 1'b1;
                            sda_oe_d  = ~tx_data[I2C_DATA_W-1];
                            state_d   = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise && !done_q) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        sda_oe_d = 1'b1;
                        done_d   = 1'b0;
                        state_d  = WRITE_ACK;
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WRITE;
                    end
                end

                READ: begin
                    // Bit 7 went out on entry; each later fall shifts the
                    // next bit onto the bus until all eight were clocked.
                    if (scl_rise && !done_q) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (done_q) begin
                            sda_oe_d = 1'b0;
                            done_d   = 1'b0;
                            state_d  = READ_ACK;
                        end else begin
                            shift_d  = {shift_q[I2C_DATA_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[I2C_DATA_W-2];
                        end
                    end
                end

                READ_ACK: begin
                    if (scl_rise && !done_q) begin
                        if (!sda_s) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && done_q) begin
                        shift_d   = tx_data;
                        tx_load_d = 1'b1;
                        sda_oe_d  = ~tx_data[I2C_DATA_W-1];
                        bit_cnt_d = '0;
                        done_d    = 1'b0;
                        state_d   = READ;
                    end
                end

                WAIT_STOP: ;

                default: state_d = IDLE;
            endcase
        end
    end

    // Open-drain: only ever pull low; the register is cleared asynchronously
    // so reset releases the line without waiting for a clock edge.
    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Bit-banged I2C master driving the target. Expected write bytes are queued
// when issued; a monitor pops and compares them whenever rx_valid pulses.
// Bus-level results (ACK bits, read bytes, busy, sda level) are compared
// against hand-computed constants as each transfer completes.
// ---------------------------------------------------------------------------
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int CLK_P = 10;
    localparam int Q     = 40;   // quarter scl period: scl = 16 clk cycles
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       m_low;
    logic [7:0] tx_data;
    wire        sda_bus;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        tx_load;
    wire        busy;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #(CLK_P/2) clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl_m),
        .sda      (sda_bus),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         txl_cnt = 0;
    logic [7:0] exp_rx_q[$];
    time        last_rise = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: compares every rx_valid against the scoreboard queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (rx_valid) begin
                rx_cnt++;
                checks++;
                if (exp_rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got rx_data %0h, expected no rx_valid", rx_data);
                end else begin
                    e = exp_rx_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_data: got %0h, expected %0h", rx_data, e);
                    end else begin
                        $display("ok   rx_data: %0h", rx_data);
                    end
                end
                checks++;
                if (($time - last_rise) != time'((SYNC + 1) * CLK_P)) begin
                    errors++;
                    $display("FAIL rx_latency: got %0t, expected %0d", $time - last_rise, (SYNC + 1) * CLK_P);
                end
                if (tx_load) begin
                    errors++;
                    $display("FAIL strobe_overlap: got rx_valid=1 tx_load=1, expected not both");
                end
            end
            if (tx_load) txl_cnt++;
        end
    end

    task automatic bit_out(input logic b);
        m_low = ~b;
        #Q;
        scl_m = 1'b1;
        last_rise = $time;
        #(2*Q);
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bit_in(output logic b);
        m_low = 1'b0;
        #Q;
        scl_m = 1'b1;
        last_rise = $time;
        #Q;
        b = sda_bus;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    // Works both from idle (scl high) and as a repeated START (scl low).
    task automatic start_c();
        m_low = 1'b0;
        #Q;
        chk("sda_released_before_start", {31'd0, sda_bus}, 32'd1);
        scl_m = 1'b1;
        #Q;
        m_low = 1'b1;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic stop_c();
        m_low = 1'b1;
        #Q;
        scl_m = 1'b1;
        #Q;
        m_low = 1'b0;
        #(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, txl0;

        rst = 1'b1; scl_m = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        #(4*CLK_P);
        chk("reset_rx_data",  {24'd0, rx_data}, 32'h00);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_tx_load",  {31'd0, tx_load}, 32'd0);
        chk("reset_busy",     {31'd0, busy}, 32'd0);
        chk("reset_sda",      {31'd0, sda_bus}, 32'd1);
        chk("reset_state",    32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        #(4*CLK_P);

        // Write 8'hAA to 0x50
        rx0 = rx_cnt;
        start_c();
        write_byte(8'hA0, ack);  chk("t1_addr_ack", {31'd0, ack}, 32'd0);
        chk("t1_busy_after_match", {31'd0, busy}, 32'd1);
        exp_rx_q.push_back(8'hAA);
        write_byte(8'hAA, ack);  chk("t1_data_ack", {31'd0, ack}, 32'd0);
        chk("t1_busy_before_stop", {31'd0, busy}, 32'd1);
        stop_c();
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("t1_rx_count", 32'(rx_cnt - rx0), 32'd1);

        // Write to 0x51: ignored
        rx0 = rx_cnt;
        start_c();
        write_byte(8'hA2, ack);  chk("t2_addr_nack", {31'd0, ack}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h33, ack);  chk("t2_data_nack", {31'd0, ack}, 32'd1);
        stop_c();
        chk("t2_rx_count", 32'(rx_cnt - rx0), 32'd0);
        rx0 = rx_cnt;
        start_c();
        write_byte(8'hA0, ack);  chk("t2b_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h5C);
        write_byte(8'h5C, ack);  chk("t2b_data_ack", {31'd0, ack}, 32'd0);
        stop_c();
        chk("t2b_rx_count", 32'(rx_cnt - rx0), 32'd1);

        // Read two bytes: ACK then NACK
        txl0 = txl_cnt;
        tx_data = 8'h3C;
        start_c();
        write_byte(8'hA1, ack);  chk("t3_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d);            chk("t3_byte1", {24'd0, d}, 32'h3C);
        tx_data = 8'hC3;
        bit_out(1'b0);
        read_byte(d);            chk("t3_byte2", {24'd0, d}, 32'hC3);
        bit_out(1'b1);
        #(4*CLK_P);
        chk("t3_sda_released_after_nack", {31'd0, sda_bus}, 32'd1);
        chk("t3_state_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
        stop_c();
        chk("t3_tx_load_count", 32'(txl_cnt - txl0), 32'd2);

        // Write 8'h11, repeated START, read 8'h7E
        rx0 = rx_cnt; txl0 = txl_cnt;
        start_c();
        write_byte(8'hA0, ack);  chk("t4_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h11);
        write_byte(8'h11, ack);  chk("t4_data_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'h7E;
        start_c();
        write_byte(8'hA1, ack);  chk("t4_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(d);            chk("t4_read_byte", {24'd0, d}, 32'h7E);
        bit_out(1'b1);
        stop_c();
        chk("t4_rx_count", 32'(rx_cnt - rx0), 32'd1);
        chk("t4_tx_load_count", 32'(txl_cnt - txl0), 32'd1);
        chk("t4_rx_data_held", {24'd0, rx_data}, 32'h11);

        // STOP after 4 data bits
        rx0 = rx_cnt;
        start_c();
        write_byte(8'hA0, ack);  chk("t5_addr_ack", {31'd0, ack}, 32'd0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        stop_c();
        chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_sda", {31'd0, sda_bus}, 32'd1);
        chk("t5_rx_count", 32'(rx_cnt - rx0), 32'd0);

        // Reset while the address ACK is being driven
        start_c();
        for (int i = 7; i >= 0; i--) bit_out(i == 7 || i == 5);  // 8'hA0
        m_low = 1'b0;
        #(CLK_P);
        chk("t6_ack_driven", {31'd0, sda_bus}, 32'd0);
        chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_sda_released_async", {31'd0, sda_bus}, 32'd1);
        chk("t6_busy_rst",     {31'd0, busy}, 32'd0);
        chk("t6_rx_data_rst",  {24'd0, rx_data}, 32'h00);
        chk("t6_rx_valid_rst", {31'd0, rx_valid}, 32'd0);
        chk("t6_tx_load_rst",  {31'd0, tx_load}, 32'd0);
        #6;
        scl_m = 1'b1;
        #(4*CLK_P);
        rst = 1'b0;
        #(4*CLK_P);

        rx0 = rx_cnt;
        start_c();
        write_byte(8'hA0, ack);  chk("t7_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'hAA);
        write_byte(8'hAA, ack);  chk("t7_data_ack", {31'd0, ack}, 32'd0);
        stop_c();
        chk("t7_rx_count", 32'(rx_cnt - rx0), 32'd1);
        chk("t7_busy_after_stop", {31'd0, busy}, 32'd0);

        #(4*CLK_P);
        chk("scoreboard_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target: the responder for the team's i2c master on the shared scl/sda bus.
- Oversamples scl/sda with the system clock, detects START/STOP, and matches its own address.
- Write transfers: ACKs the address and each data byte, and delivers each received byte on a one-cycle strobe.
- Read transfers: shifts out bytes supplied by the local side and honours the master's ACK/NACK.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- SYNC_STAGES, 2, synchronizer depth on scl and sda inputs (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the scl frequency.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock; the target never stretches scl.
- sda  inout  1  open-drain data; driven 0 or high-Z, never driven 1.
- tx_data  input  8  byte to transmit on reads; sampled when tx_load pulses.
- rx_data  output  8  last byte received on a write; holds until the next byte.
- rx_valid  output  1  one-cycle strobe: rx_data updated.
- tx_load  output  1  one-cycle strobe: tx_data captured into the shift register.
- busy  output  1  high from an address match until STOP or return to IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sda high-Z, rx_data=0, rx_valid=0, tx_load=0, busy=0.
  - Bit counter and shift registers are cleared.
- Input conditioning:
  - scl and sda each pass through SYNC_STAGES flops plus one history flop.
  - scl_rise/scl_fall are single-cycle pulses from the synced scl.
- Bus conditions:
  - START: synced sda falls while synced scl is high. STOP: synced sda rises while synced scl is high.
  - Both take priority over every state.
  - STOP in any state: go to IDLE, release sda, busy=0.
  - START in any state, including repeated START: go to ADDR with the bit counter at 0.
- Bit timing:
  - Sample sda on scl_rise.
  - Change the own sda drive only on scl_fall.
  - Shift MSB first. A 3-bit counter counts bits 7..0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (addr[6:0], rw).
    - On the 8th scl_rise, compare addr with SLAVE_ADDR.
    - Match: set busy=1. On the next scl_fall, drive sda=0 and go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP without driving sda.
  - ADDR_ACK: hold sda=0 through the 9th clock; on its scl_fall, release or load:
    - rw=0: release sda and go to WRITE.
    - rw=1: capture tx_data, pulse tx_load, drive bit 7 and go to READ.
  - WRITE: shift 8 bits.
    - On the 8th scl_rise, write rx_data and pulse rx_valid in the same clk cycle.
    - Next scl_fall: drive sda=0 and go to WRITE_ACK.
  - WRITE_ACK: hold ACK; on the 9th scl_fall, release sda and go to WRITE.
  - READ: drive the current bit on each scl_fall.
    - After bit 0, release sda on the 8th scl_fall and go to READ_ACK.
  - READ_ACK: sample master ACK on the 9th scl_rise.
    - ACK (sda=0): on scl_fall, capture tx_data, pulse tx_load, drive bit 7 and go to READ.
    - NACK (sda=1): go to WAIT_STOP with sda released.
  - WAIT_STOP: sda released, busy unchanged; exit only on STOP (to IDLE) or START (to ADDR).
- Latency:
  - rx_valid asserts SYNC_STAGES+1 clk cycles after the pin-level 8th scl rising edge.
  - tx_data must be stable on the clk cycle tx_load pulses. It is also captured before the first read bit, so the local side sets it ahead of the transfer.
- Simultaneous events: a STOP/START detected in the same cycle as scl_fall wins; no ACK drive occurs.
- Reset mid-transfer releases sda immediately, asynchronously.
- rx_valid and tx_load never assert in the same cycle.

Decomposition:
- Shared package i2c_pkg:
  - State encoding enum: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
  - Constants: I2C_ADDR_W=7, I2C_DATA_W=8, I2C_RW_READ=1'b1.
- One natural sub-module: i2c_bus_sync.
  - SYNC_STAGES synchronizer plus edge/condition detect.
  - Outputs scl_rise, scl_fall, start_det, stop_det and synced sda.
  - Reusable by the master.

Test Plan:
- Write to 7'h50 with data 8'hAA (the master's default stimulus):
  - sda held low during the address ACK and the data ACK.
  - rx_valid pulses exactly once with rx_data=8'hAA; busy=1 until STOP, then 0.
- Write to 7'h51:
  - sda never driven (ACK bit reads 1), no rx_valid, busy stays 0.
  - After STOP, a write to 7'h50 of 8'h5C is received correctly.
- Read from 7'h50, tx_data=8'h3C then 8'hC3, master ACKs byte 1 and NACKs byte 2:
  - Bus shows 8'h3C then 8'hC3; tx_load pulses twice; sda released after the NACK.
- Write 8'h11, then repeated START to a read with tx_data=8'h7E:
  - rx_data=8'h11 with one rx_valid; the read returns 8'h7E; no spurious ACK around the repeated START.
- STOP after 4 bits of a write byte: state returns to IDLE, no rx_valid, sda high-Z, busy=0.
- rst=1 while driving an ACK low: sda is high-Z within the same cycle, all outputs are at reset values, and the next write of 8'hAA is received correctly.
